fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode stage. Holds the program counter, issues word reads to instruction memory, buffers returned words in a small FIFO and presents one instruction per cycle to decode with a valid/ready handshake. Takes branch redirects from downstream as a 21-bit word address, flushes buffered and in-flight words, and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int BADDR_W = 21;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

    // Branch targets only carry a 21-bit word address; the upper bits come from the fetch pc.
    function automatic logic [31:0] redirect_target(input logic [31:0]        pc,
                                                    input logic [BADDR_W-1:0] baddr);
        return {pc[31:23], baddr, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, decode handshake and branch redirect.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_rvalid;
    logic [INST_W-1:0]   imem_rdata;
    logic [INST_W-1:0]   inst;
    logic [31:0]         inst_pc;
    logic                inst_valid;
    logic                inst_ready;
    logic                redirect;
    logic [BADDR_W-1:0]  redirect_baddr;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_baddr
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_baddr
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer with synchronous flush; head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;

    assign pop_ok = pop & (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc, single-outstanding imem reads, buffered delivery to decode.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  stat_fetched,
    output logic [31:0]  stat_flushed
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t      state;
    logic [31:0]       pc;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              issue;
    logic              push;
    logic              pop;

    // Issue only from IDLE, so count alone bounds buffered + outstanding words.
    assign issue      = (state == IDLE) & ~bus.redirect & (count < DEPTH_C);
    assign push       = (state == WAIT) & bus.imem_rvalid & ~bus.redirect;
    assign bus.inst_valid = (count != '0);
    assign pop        = bus.inst_valid & bus.inst_ready;
    assign push_entry = '{inst: bus.imem_rdata, pc: bus.imem_addr};
    assign bus.inst    = head.inst;
    assign bus.inst_pc = head.pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .count      (count),
        .head       (head)
    );

    // imem_addr holds the outstanding request address until the next issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
        end else begin
            bus.imem_req <= issue;
            if (issue) bus.imem_addr <= pc;
            if (bus.redirect)  pc <= redirect_target(pc, bus.redirect_baddr);
            else if (issue)    pc <= pc + 32'd4;
            unique case (state)
                IDLE:    if (issue) state <= WAIT;
                WAIT:    if (bus.imem_rvalid) state <= IDLE;
                         else if (bus.redirect) state <= DROP;
                DROP:    if (bus.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // A word popped in the redirect cycle was delivered, so it is not counted as flushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (pop) stat_fetched <= stat_fetched + 32'd1;
            if (bus.redirect)
                stat_flushed <= stat_flushed + 32'(count) - 32'(pop) + 32'(state == WAIT);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle vector table plus redirect, stall, wrap and stats sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

`ifdef FETCH_STATS_EN
    logic [31:0] sf1, sfl1, sf2, sfl2;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (sf1),
        .stat_flushed (sfl1)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (sf2),
        .stat_flushed (sfl2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory for dut: one outstanding read, configurable latency.
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    always @(negedge clk) begin
        bus.imem_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(paddr);
                pend = 1'b0;
            end
        end
        if (bus.imem_req === 1'b1) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = bus.imem_addr;
        end
    end

    // Memory for dut2: fixed 1-cycle latency.
    logic        p2 = 1'b0;
    logic [31:0] a2 = '0;
    always @(negedge clk) begin
        bus2.imem_rvalid = p2;
        bus2.imem_rdata  = mem_word(a2);
        p2 = (bus2.imem_req === 1'b1);
        a2 = bus2.imem_addr;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect  = 1'b0;
        bus2.redirect = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name, output logic [31:0] a);
        a = 'x;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.imem_req) begin
                a = bus.imem_addr;
                return;
            end
        end
        timeout(name);
    endtask

    task automatic wait_deliver(input string name, output logic [31:0] pc, output logic [31:0] ins);
        pc  = 'x;
        ins = 'x;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.inst_valid && bus.inst_ready) begin
                pc  = bus.inst_pc;
                ins = bus.inst;
                return;
            end
        end
        timeout(name);
    endtask

    task automatic pulse_redirect(input logic [20:0] baddr);
        @(negedge clk);
        bus.redirect       = 1'b1;
        bus.redirect_baddr = baddr;
        @(negedge clk);
        bus.redirect = 1'b0;
    endtask

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        chk_head;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, p, w;
        logic [31:0] dpc[2];
        int          nreq, nd, early;
        logic        got;

        rst_n = 1'b0;
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_baddr = '0;
        bus2.inst_ready = 1'b1;
        bus2.redirect = 1'b0;
        bus2.redirect_baddr = '0;

        // Per-edge expectations from reset, 1-cycle memory, decode always ready.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   32'h0,         1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   32'h0,         1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,         1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 32'hDEAD_0100, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,         1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   32'h0,         1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 32'h104, 32'hDEAD_0104, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0,   32'h0,         1'b0};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            bus.inst_ready = vecs[i].ready;
            @(posedge clk); #1;
            check32($sformatf("vec%0d_req", i),   32'(bus.imem_req),   32'(vecs[i].req));
            check32($sformatf("vec%0d_addr", i),  bus.imem_addr,       vecs[i].addr);
            check32($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(vecs[i].valid));
            if (vecs[i].chk_head) begin
                check32($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].pc);
                check32($sformatf("vec%0d_inst", i),    bus.inst,    vecs[i].inst);
            end
        end

        // Decode stalled: buffer fills to DEPTH, then drains in order and fetch resumes.
        do_reset();
`ifdef FETCH_STATS_EN
        check32("stat_fetched_reset", sf1, 32'h0);
        check32("stat_flushed_reset", sfl1, 32'h0);
`endif
        bus.inst_ready = 1'b0;
        nreq = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.imem_req) nreq++;
        end
        check32("stall_req_count", 32'(nreq), 32'd2);
        check32("stall_valid", 32'(bus.inst_valid), 32'd1);
        check32("stall_head_pc", bus.inst_pc, 32'h100);
        @(negedge clk);
        bus.inst_ready = 1'b1;
        nd = 0;
        got = 1'b0;
        a = 'x;
        for (int i = 0; i < 20 && !(got && nd == 2); i++) begin
            if (bus.inst_valid && bus.inst_ready && nd < 2) begin
                dpc[nd] = bus.inst_pc;
                nd++;
            end
            @(posedge clk); #1;
            if (bus.imem_req && !got) begin
                a = bus.imem_addr;
                got = 1'b1;
            end
        end
        check32("drain_pc0", dpc[0], 32'h100);
        check32("drain_pc1", dpc[1], 32'h104);
        check32("resume_addr", a, 32'h108);

        // Redirect while waiting on a slow memory: late data is discarded.
        lat = 4;
        do_reset();
        wait_req("slow_req0", a);
        check32("slow_req0_addr", a, 32'h100);
        pulse_redirect(21'h00040);
        #1;
        check32("slow_flush_valid", 32'(bus.inst_valid), 32'd0);
        early = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.inst_valid) early++;
            if (bus.imem_req) begin
                a = bus.imem_addr;
                got = 1'b1;
            end
        end
        if (!got) timeout("slow_refetch");
        check32("slow_no_stale", 32'(early), 32'd0);
        check32("slow_refetch_addr", a, 32'h100);
        wait_deliver("slow_deliver", p, w);
        check32("slow_first_pc", p, 32'h100);
        check32("slow_first_inst", w, 32'hDEAD_0100);

        // Redirect coincident with the returning word.
        lat = 1;
        do_reset();
        wait_req("coin_req0", a);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.imem_rvalid) got = 1'b1;
        end
        if (!got) timeout("coin_rvalid");
        bus.redirect = 1'b1;
        bus.redirect_baddr = 21'h00080;
        @(posedge clk); #1;
        check32("coin_not_buffered", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        bus.redirect = 1'b0;
        @(posedge clk); #1;
        check32("coin_issue_req", 32'(bus.imem_req), 32'd1);
        check32("coin_issue_addr", bus.imem_addr, 32'h200);
        wait_deliver("coin_deliver", p, w);
        check32("coin_first_pc", p, 32'h200);
        check32("coin_first_inst", w, 32'hDEAD_0200);

        // Target upper bits follow the current pc.
        do_reset();
        wait_req("tgt_req0", a);
        pulse_redirect(21'h1FFFFF);
        wait_req("tgt_req1", a);
        check32("tgt_low_addr", a, 32'h007F_FFFC);
        pulse_redirect(21'h1FFFFF);
        wait_req("tgt_req2", a);
        check32("tgt_high_addr", a, 32'h00FF_FFFC);

        // pc wraps from the top of the address space.
        do_reset();
        nreq = 0;
        for (int i = 0; i < 30 && nreq < 3; i++) begin
            @(posedge clk); #1;
            if (bus2.imem_req) begin
                if (nreq == 0) check32("wrap_req0", bus2.imem_addr, 32'hFFFF_FFF8);
                if (nreq == 1) check32("wrap_req1", bus2.imem_addr, 32'hFFFF_FFFC);
                if (nreq == 2) check32("wrap_req2", bus2.imem_addr, 32'h0000_0000);
                nreq++;
            end
        end
        if (nreq < 3) timeout("wrap_reqs");

`ifdef FETCH_STATS_EN
        // Five deliveries, then flush two buffered words plus one in flight.
        do_reset();
        #1;
        check32("stat2_fetched_reset", sf2, 32'h0);
        check32("stat2_flushed_reset", sfl2, 32'h0);
        begin
            int hs, occ;
            logic done;
            hs = 0;
            occ = 0;
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                @(negedge clk); #1;
                bus2.inst_ready = (hs < 5);
                if (hs == 5 && occ == 2 && bus2.imem_req) begin
                    bus2.redirect = 1'b1;
                    bus2.redirect_baddr = 21'h00010;
                    done = 1'b1;
                end else begin
                    if (bus2.imem_rvalid) occ++;
                    if (bus2.inst_valid && bus2.inst_ready) begin
                        occ--;
                        hs++;
                    end
                end
            end
            if (!done) timeout("stats_setup");
            @(posedge clk); #1;
            check32("stat_fetched", sf2, 32'd5);
            check32("stat_flushed", sfl2, 32'd3);
            check32("stat_flush_valid", 32'(bus2.inst_valid), 32'd0);
            @(negedge clk);
            bus2.redirect = 1'b0;
            bus2.inst_ready = 1'b1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
